// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
package counter_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // Bits needed to hold values 0..v-1, for callers sizing WIDTH from MODULUS.
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned     r;
        longint unsigned x;
        r = 0;
        x = (v > 64'd0) ? v - 64'd1 : 64'd0;
        while (x > 64'd0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_reg.sv
// W-bit D register with asynchronous active-low clear; W=1 is the plain flip-flop.
module dff_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= d;
    end

endmodule

// File: rtl/sync_counter_n.sv
// Parametrised up/down modulus counter with load, clear, optional saturation,
// combinational terminal count and a registered wrap pulse.
module sync_counter_n
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "sync_counter_n: WIDTH must be in 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "sync_counter_n: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic [WIDTH:0]   state_q;

    // Next state: clear beats load beats count; wrap only flags a boundary crossing.
    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (64'(load_val) < MODULUS) ? load_val : MAX;
        end else if (en) begin
            if (up == CNT_UP) begin
                if (count != MAX) begin
                    count_d = count + WIDTH'(1);
                end else if (!SATURATE) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    count_d = count - WIDTH'(1);
                end else if (!SATURATE) begin
                    count_d = MAX;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    dff_reg #(.W(WIDTH + 1)) u_state (
        .clk (clk),
        .rst (rst),
        .d   ({wrap_d, count_d}),
        .q   (state_q)
    );

    assign count = state_q[WIDTH-1:0];
    assign wrap  = state_q[WIDTH];

    assign tc = en & (((up == CNT_UP)   && (count == MAX)) ||
                      ((up == CNT_DOWN) && (count == '0)));

endmodule

// File: tb/tb_sync_counter_n.sv
// Scoreboard bench: a wrapping modulus-10 counter and a saturating modulus-16 counter.
module tb_sync_counter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, wrap_a, wrap_b;

    typedef struct {
        bit    sel;
        int    cnt;
        bit    wrap;
        bit    tc;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int up_exp[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    int dn_exp[10] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

    always #5 clk = ~clk;

    sync_counter_n #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count_a), .tc(tc_a), .wrap(wrap_a)
    );

    sync_counter_n #(.WIDTH(4), .MODULUS(64'd16), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count_b), .tc(tc_b), .wrap(wrap_b)
    );

    function automatic void check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endfunction

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input bit sel, input bit e, input bit u, input bit c, input bit l,
                        input logic [3:0] lv, input int ecnt, input bit ewrap, input bit etc,
                        input string nm);
        exp_t x;
        @(negedge clk);
        en = e; up = u; clr = c; load = l; load_val = lv;
        x.sel = sel; x.cnt = ecnt; x.wrap = ewrap; x.tc = etc; x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #2;
        check("scoreboard drain", sb.size(), 0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check({x.nm, " count"}, x.sel ? int'(count_b) : int'(count_a), x.cnt);
                check({x.nm, " wrap"},  x.sel ? int'(wrap_b)  : int'(wrap_a),  int'(x.wrap));
                check({x.nm, " tc"},    x.sel ? int'(tc_b)    : int'(tc_a),    int'(x.tc));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset count_a", int'(count_a), 0);
        check("reset wrap_a",  int'(wrap_a),  0);
        check("reset tc_a",    int'(tc_a),    0);
        check("reset count_b", int'(count_b), 0);
        en = 1'b1; up = 1'b0;
        #1;
        check("reset tc_a down", int'(tc_a), 1);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            step(0, 1, 1, 0, 0, 4'd0, up_exp[i], i == 9, up_exp[i] == 9, "up");
        for (int i = 0; i < 10; i++)
            step(0, 1, 0, 0, 0, 4'd0, dn_exp[i], i == 0, dn_exp[i] == 0, "down");

        step(0, 0, 0, 0, 1, 4'd6,  6, 0, 0, "load6");
        step(0, 0, 0, 0, 1, 4'd14, 9, 0, 0, "load14 clamp");
        step(0, 0, 0, 0, 1, 4'd5,  5, 0, 0, "load5");
        step(0, 1, 1, 1, 1, 4'd3,  0, 0, 0, "clr priority");
        step(0, 1, 1, 0, 1, 4'd3,  3, 0, 0, "load over en");

        step(1, 0, 0, 0, 1, 4'd15, 15, 0, 0, "sat load15");
        for (int i = 0; i < 3; i++)
            step(1, 1, 1, 0, 0, 4'd0, 15, 0, 1, "sat hold top");
        step(1, 1, 0, 0, 0, 4'd0, 14, 0, 0, "sat down");
        step(1, 0, 0, 0, 1, 4'd0,  0, 0, 0, "sat load0");
        for (int i = 0; i < 2; i++)
            step(1, 1, 0, 0, 0, 4'd0, 0, 0, 1, "sat hold bottom");

        step(0, 0, 0, 0, 1, 4'd7, 7, 0, 0, "load7");
        drain();

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        load = 1'b0; en = 1'b0; up = 1'b1;
        rst = 1'b0;
        #1;
        check("async count_a", int'(count_a), 0);
        check("async wrap_a",  int'(wrap_a),  0);
        check("async tc_a",    int'(tc_a),    0);
        en = 1'b1; up = 1'b0;
        #1;
        check("async tc_a down", int'(tc_a), 1);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        step(0, 1, 1, 0, 0, 4'd0, 1, 0, 0, "resume");
        step(0, 1, 0, 0, 0, 4'd0, 0, 0, 1, "dir change");
        step(0, 1, 0, 0, 0, 4'd0, 9, 1, 0, "down wrap");
        step(0, 0, 0, 0, 0, 4'd0, 9, 0, 0, "hold");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_counter_n.md
# sync_counter_n

Parametrised synchronous binary counter that generalises the team's fixed 4-bit up counter to WIDTH bits, an arbitrary modulus, up/down direction, synchronous load/clear and optional saturation. It is the standard count/timebase element for dividers, event counters and display sequencing. Every state bit is held in the shared D-flip-flop register cell, so reset behaviour is identical across all counters in the design.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULUS, 2**WIDTH, count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  load data.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal count (combinational).
- wrap  out  1  registered one-cycle pulse, asserted in the cycle after a wrap.

## Operation
- Priority of the next-state update, evaluated each rising edge: clr, then load, then en, then hold.
- clr=1: count <= 0 and wrap <= 0, regardless of the other inputs.
- load=1:
  - count <= load_val when load_val < MODULUS, otherwise count <= MODULUS-1.
  - wrap <= 0.
- en=1 and up=1:
  - count < MODULUS-1: count <= count+1.
  - count = MODULUS-1, SATURATE=0: count <= 0 and wrap <= 1.
  - count = MODULUS-1, SATURATE=1: count holds and wrap <= 0.
- en=1 and up=0:
  - count > 0: count <= count-1.
  - count = 0, SATURATE=0: count <= MODULUS-1 and wrap <= 1.
  - count = 0, SATURATE=1: count holds and wrap <= 0.
- No enabled step (including clr=0, load=0, en=0): count holds and wrap <= 0.
- tc = en & ((up & count==MODULUS-1) | (~up & count==0)). tc is independent of clr/load and asserts in SATURATE mode too.
- Arithmetic uses WIDTH-bit compares against the constant MODULUS-1. No internal state outside count and wrap exists, so the counter has no FSM.
- Direction may change on any cycle; the next step uses the up value sampled at that edge.

## Timing
- Reset (rst=0, asynchronous): count=0 and wrap=0 immediately, independent of clk. tc then follows its equation (tc=1 if en=1 and up=0).
- Release of rst is synchronous in effect: the first update happens on the first rising edge with rst=1.
- Reset mid-count discards the value; there is no resume.
- Latency:
  - count changes one edge after en, load or clr is sampled.
  - tc is valid in the same cycle as count (zero latency).
  - wrap is high for exactly one cycle, coincident with the wrapped value appearing on count.
- Back-to-back wraps (MODULUS=2, en held) produce a wrap pulse on every other cycle, matching each wrap event.

## Structure
- Shared package counter_pkg:
  - Direction constants CNT_UP=1'b1 and CNT_DOWN=1'b0.
  - Function clog2 for callers that size WIDTH from MODULUS.
- Sub-module dff_reg (parameter W) holds count and wrap: W-bit D register with rst active-low asynchronous clear. The existing single-bit DFlipFlop is the W=1 case.
- Next-state logic and tc are combinational in sync_counter_n itself.
- Elaboration check: MODULUS > 2**WIDTH or MODULUS < 2 is a fatal error.

## Test plan
- WIDTH=4, MODULUS=10, up=1, en=1 from reset -> count 0,1,…,9,0. wrap is high only in the cycle count returns to 0. tc is high while count=9.
- Same configuration with up=0 -> count 0,9,8,…,0. wrap is high in the cycle count=9. tc is high while count=0.
- load=1 with load_val=6, then load=1 with load_val=14 -> count=6, then count=9 (clamped). wrap stays 0.
- clr=1, load=1 and en=1 in the same cycle at count=5 -> count=0 on the next edge. A subsequent load=1 with en=1 loads rather than counts.
- SATURATE=1, MODULUS=16, count at 15, up=1, en=1 for 3 cycles -> count stays 15, wrap never asserts, tc stays 1.
- rst pulled low asynchronously mid-cycle at count=7 -> count=0 and wrap=0 before the next clk edge. Counting resumes from 0 on the first edge after rst=1.
